// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch stage. Owns the PC, loads the start PC from a
//             two-word reset vector, follows the hazard unit's pcSrc decision,
//             and assembles 16- or 32-bit instructions into the IF/ID
//             pipeline register outputs.
//
//  Ports    :
//     clk           in   rising-edge clock
//     rst           in   synchronous, active-high reset
//     pcSrc         in   00 sequential, 01 branch, 10 stall/bubble, 11 = 00
//     branchTarget  in   redirect destination (used when pcSrc = 01)
//     instrWord     in   combinational instruction-memory read data
//     imemAddr      out  combinational instruction-memory address
//     instrOut      out  IF/ID instruction word
//     immOut        out  IF/ID immediate word (0 for one-word instructions)
//     fetchedPc     out  IF/ID address of the instruction's first word
//     validOut      out  IF/ID holds a real instruction
//     flushOut      out  one-cycle pulse after a branch redirect
//
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
   parameter int PC_WIDTH   = 32,
   parameter int WORD_WIDTH = 16,
   parameter int VEC_ADDR   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            pcSrc,
   input  logic [PC_WIDTH-1:0]   branchTarget,
   input  logic [WORD_WIDTH-1:0] instrWord,
   output logic [PC_WIDTH-1:0]   imemAddr,
   output logic [WORD_WIDTH-1:0] instrOut,
   output logic [WORD_WIDTH-1:0] immOut,
   output logic [PC_WIDTH-1:0]   fetchedPc,
   output logic                  validOut,
   output logic                  flushOut
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   // Both vector addresses are computed in PC_WIDTH arithmetic so that the
   // low-word address wraps like every other PC value.
   localparam logic [PC_WIDTH-1:0] C_VEC_HI = PC_WIDTH'(VEC_ADDR);
   localparam logic [PC_WIDTH-1:0] C_VEC_LO = C_VEC_HI + PC_WIDTH'(1);

   localparam logic [1:0] C_SRC_BRANCH = 2'b01;
   localparam logic [1:0] C_SRC_STALL  = 2'b10;

   typedef enum logic [1:0] {
      ST_VEC_HI    = 2'd0,
      ST_VEC_LO    = 2'd1,
      ST_FETCH     = 2'd2,
      ST_FETCH_IMM = 2'd3
   } state_t;

   // -------------------------------------------------------------------------
   // State and IF/ID registers
   // -------------------------------------------------------------------------
   state_t                  state_q,   state_d;
   logic [PC_WIDTH-1:0]     pc_q,      pc_d;
   logic [WORD_WIDTH-1:0]   pend_q,    pend_d;
   logic [WORD_WIDTH-1:0]   instr_q,   instr_d;
   logic [WORD_WIDTH-1:0]   imm_q,     imm_d;
   logic [PC_WIDTH-1:0]     fpc_q,     fpc_d;
   logic                    valid_q,   valid_d;
   logic                    flush_q,   flush_d;

   logic                    w_redirect;
   logic                    w_stall;
   logic                    w_two_word;
   logic [PC_WIDTH-1:0]     w_pc_inc;

   // Redirect outranks stall; the reserved code 11 falls through to
   // sequential fetch because it matches neither decode.
   assign w_redirect = (pcSrc == C_SRC_BRANCH);
   assign w_stall    = (pcSrc == C_SRC_STALL);

   // Bit 0 of the first word marks an instruction that carries an immediate.
   assign w_two_word = instrWord[0];

   // Modulo 2^PC_WIDTH increment: the carry out of the top bit is dropped.
   assign w_pc_inc   = pc_q + PC_WIDTH'(1);

   // -------------------------------------------------------------------------
   // Memory address: the vector words during boot, the PC afterwards.
   // -------------------------------------------------------------------------
   always_comb begin
      case (state_q)
         ST_VEC_HI: imemAddr = C_VEC_HI;
         ST_VEC_LO: imemAddr = C_VEC_LO;
         default:   imemAddr = pc_q;
      endcase
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
      instr_d = instr_q;
      imm_d   = imm_q;
      fpc_d   = fpc_q;
      valid_d = valid_q;
      // The flush pulse lasts exactly one cycle unless re-armed below.
      flush_d = 1'b0;

      case (state_q)
         // The vector is read unconditionally; the hazard unit has nothing
         // meaningful to say before the first real fetch.
         ST_VEC_HI: begin
            pc_d[PC_WIDTH-1 -: WORD_WIDTH] = instrWord;
            state_d                        = ST_VEC_LO;
         end

         ST_VEC_LO: begin
            pc_d[WORD_WIDTH-1:0] = instrWord;
            state_d              = ST_FETCH;
         end

         ST_FETCH: begin
            if (w_redirect) begin
               pc_d    = branchTarget;
               valid_d = 1'b0;
               flush_d = 1'b1;
            end else if (w_stall) begin
               // Bubble: PC and IF/ID contents hold.
               state_d = ST_FETCH;
            end else if (w_two_word) begin
               // Park the first word and emit a bubble while the immediate
               // is fetched; fetchedPc already points at the first word.
               pend_d  = instrWord;
               fpc_d   = pc_q;
               pc_d    = w_pc_inc;
               valid_d = 1'b0;
               state_d = ST_FETCH_IMM;
            end else begin
               instr_d = instrWord;
               imm_d   = '0;
               fpc_d   = pc_q;
               valid_d = 1'b1;
               pc_d    = w_pc_inc;
            end
         end

         ST_FETCH_IMM: begin
            if (w_redirect) begin
               // The parked first word is dropped; it never reaches IF/ID.
               pc_d    = branchTarget;
               valid_d = 1'b0;
               flush_d = 1'b1;
               state_d = ST_FETCH;
            end else if (w_stall) begin
               state_d = ST_FETCH_IMM;
            end else begin
               instr_d = pend_q;
               imm_d   = instrWord;
               valid_d = 1'b1;
               pc_d    = w_pc_inc;
               state_d = ST_FETCH;
            end
         end

         default: begin
            state_d = ST_VEC_HI;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_VEC_HI;
         pc_q    <= '0;
         pend_q  <= '0;
         instr_q <= '0;
         imm_q   <= '0;
         fpc_q   <= '0;
         valid_q <= 1'b0;
         flush_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         instr_q <= instr_d;
         imm_q   <= imm_d;
         fpc_q   <= fpc_d;
         valid_q <= valid_d;
         flush_q <= flush_d;
      end
   end

   assign instrOut  = instr_q;
   assign immOut    = imm_q;
   assign fetchedPc = fpc_q;
   assign validOut  = valid_q;
   assign flushOut  = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit. An instruction memory is
//             modelled as a 256-entry array indexed by the low address byte.
//             A reference model follows the fetch rules at the level of
//             "boot words read / instruction in flight" and is compared
//             against the DUT every cycle; directed scenarios add literal
//             expectations, followed by a randomized run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic [1:0]  pcSrc;
   logic [31:0] branchTarget;
   logic [15:0] instrWord;
   logic [31:0] imemAddr;
   logic [15:0] instrOut;
   logic [15:0] immOut;
   logic [31:0] fetchedPc;
   logic        validOut;
   logic        flushOut;

   logic [15:0] mem [0:255];

   int tests = 0;
   int fails = 0;
   bit chk_en = 0;

   fetch_unit #(
      .PC_WIDTH   (32),
      .WORD_WIDTH (16),
      .VEC_ADDR   (0)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pcSrc        (pcSrc),
      .branchTarget (branchTarget),
      .instrWord    (instrWord),
      .imemAddr     (imemAddr),
      .instrOut     (instrOut),
      .immOut       (immOut),
      .fetchedPc    (fetchedPc),
      .validOut     (validOut),
      .flushOut     (flushOut)
   );

   assign instrWord = mem[imemAddr[7:0]];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // -------------------------------------------------------------------------
   // Reference model
   //   m_boot : number of vector words still to read (2, 1, 0)
   //   m_wait : a two-word instruction's first word is held, immediate next
   // -------------------------------------------------------------------------
   int          m_boot;
   bit          m_wait;
   logic [15:0] m_first;
   logic [31:0] m_pc;
   logic [15:0] m_instr, m_imm;
   logic [31:0] m_fpc;
   bit          m_valid, m_flush;

   function automatic logic [31:0] model_addr();
      if (m_boot == 2) return 32'd0;
      if (m_boot == 1) return 32'd1;
      return m_pc;
   endfunction

   always @(posedge clk) begin : model
      int          boot;
      bit          wt;
      logic [15:0] first, instr, imm, w;
      logic [31:0] pc, fpc;
      bit          valid, flush;

      boot = m_boot; wt = m_wait; first = m_first; pc = m_pc;
      instr = m_instr; imm = m_imm; fpc = m_fpc; valid = m_valid;
      flush = 1'b0;
      w = mem[model_addr() % 256];

      if (rst) begin
         boot = 2; wt = 0; first = 0; pc = 0;
         instr = 0; imm = 0; fpc = 0; valid = 0;
      end else if (boot == 2) begin
         pc = {w, pc[15:0]};
         boot = 1;
      end else if (boot == 1) begin
         pc = {pc[31:16], w};
         boot = 0;
      end else if (pcSrc == 2'b01) begin
         pc = branchTarget; valid = 0; flush = 1; wt = 0;
      end else if (pcSrc == 2'b10) begin
         // nothing moves
      end else if (wt) begin
         instr = first; imm = w; valid = 1; pc = pc + 1; wt = 0;
      end else if (w[0]) begin
         first = w; fpc = pc; pc = pc + 1; valid = 0; wt = 1;
      end else begin
         instr = w; imm = 0; fpc = pc; valid = 1; pc = pc + 1;
      end

      m_boot <= boot; m_wait <= wt; m_first <= first; m_pc <= pc;
      m_instr <= instr; m_imm <= imm; m_fpc <= fpc;
      m_valid <= valid; m_flush <= flush;
   end

   // Every-cycle comparison, half a clock away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("imemAddr",  {32'd0, imemAddr},  {32'd0, model_addr()});
         check("instrOut",  {48'd0, instrOut},  {48'd0, m_instr});
         check("immOut",    {48'd0, immOut},    {48'd0, m_imm});
         check("fetchedPc", {32'd0, fetchedPc}, {32'd0, m_fpc});
         check("validOut",  {63'd0, validOut},  {63'd0, m_valid});
         check("flushOut",  {63'd0, flushOut},  {63'd0, m_flush});
      end
   end

   // -------------------------------------------------------------------------
   // Stimulus helpers: inputs change 1 time unit after the rising edge.
   // -------------------------------------------------------------------------
   task automatic cyc(input logic [1:0] src, input logic [31:0] bt);
      pcSrc        = src;
      branchTarget = bt;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(2'b00, 32'd0);
      rst = 1'b0;
   endtask

   task automatic load_two_word_prog();
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[1]    = 16'h0020;
      mem[8'h20] = 16'h2001;
      mem[8'h21] = 16'hBEEF;
      mem[8'h22] = 16'h3000;
   endtask

   initial begin
      int r;
      rst = 1'b1;
      pcSrc = 2'b00;
      branchTarget = 32'd0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

      // ---- 1: reset vector -------------------------------------------------
      mem[1]     = 16'h0020;
      mem[8'h20] = 16'h1000;
      cyc(2'b00, 32'd0);
      chk_en = 1;
      cyc(2'b00, 32'd0);
      rst = 1'b0;
      check("t1_addr_vec_hi", {32'd0, imemAddr}, 64'h0);
      check("t1_valid_rst",   {63'd0, validOut}, 64'h0);
      cyc(2'b00, 32'd0);
      check("t1_addr_vec_lo", {32'd0, imemAddr}, 64'h1);
      check("t1_valid_boot",  {63'd0, validOut}, 64'h0);
      cyc(2'b00, 32'd0);
      check("t1_addr_start",  {32'd0, imemAddr}, 64'h20);
      check("t1_valid_boot2", {63'd0, validOut}, 64'h0);
      cyc(2'b00, 32'd0);
      check("t1_instr",  {48'd0, instrOut},  64'h1000);
      check("t1_fpc",    {32'd0, fetchedPc}, 64'h20);
      check("t1_valid",  {63'd0, validOut},  64'h1);
      check("t1_model_pc", {32'd0, m_pc},    64'h21);

      // ---- 2/3: two-word instruction, then bubble at 0x22 -----------------
      load_two_word_prog();
      do_reset();
      cyc(2'b00, 32'd0);
      cyc(2'b00, 32'd0);
      cyc(2'b00, 32'd0);
      check("t2_bubble_valid", {63'd0, validOut}, 64'h0);
      check("t2_addr_imm",     {32'd0, imemAddr}, 64'h21);
      cyc(2'b00, 32'd0);
      check("t2_instr", {48'd0, instrOut},  64'h2001);
      check("t2_imm",   {48'd0, immOut},    64'hBEEF);
      check("t2_fpc",   {32'd0, fetchedPc}, 64'h20);
      check("t2_valid", {63'd0, validOut},  64'h1);
      for (int k = 0; k < 3; k++) begin
         cyc(2'b10, 32'h0000_0055);
         check("t3_addr",  {32'd0, imemAddr}, 64'h22);
         check("t3_instr", {48'd0, instrOut}, 64'h2001);
         check("t3_fpc",   {32'd0, fetchedPc}, 64'h20);
         check("t3_valid", {63'd0, validOut}, 64'h1);
         check("t3_flush", {63'd0, flushOut}, 64'h0);
      end
      cyc(2'b00, 32'd0);
      check("t2_instr2", {48'd0, instrOut},  64'h3000);
      check("t2_imm2",   {48'd0, immOut},    64'h0);
      check("t2_fpc2",   {32'd0, fetchedPc}, 64'h22);

      // ---- 4: branch while the immediate is pending ------------------------
      load_two_word_prog();
      mem[0] = 16'h0000;
      do_reset();
      mem[8'h00] = 16'h4000;          // target 0x100 aliases index 0x00
      cyc(2'b00, 32'd0);
      cyc(2'b00, 32'd0);
      cyc(2'b00, 32'd0);
      cyc(2'b01, 32'h0000_0100);
      check("t4_valid", {63'd0, validOut}, 64'h0);
      check("t4_flush", {63'd0, flushOut}, 64'h1);
      check("t4_addr",  {32'd0, imemAddr}, 64'h100);
      check("t4_imm",   {48'd0, immOut},   64'h0);
      cyc(2'b00, 32'd0);
      check("t4_flush_end", {63'd0, flushOut}, 64'h0);
      check("t4_instr", {48'd0, instrOut},  64'h4000);
      check("t4_fpc",   {32'd0, fetchedPc}, 64'h100);

      // ---- 4b: back-to-back redirects keep flush high ----------------------
      cyc(2'b01, 32'h0000_0040);
      cyc(2'b01, 32'h0000_0080);
      check("t4b_flush", {63'd0, flushOut}, 64'h1);
      check("t4b_addr",  {32'd0, imemAddr}, 64'h80);

      // ---- 5: wrap-around --------------------------------------------------
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      do_reset();
      mem[0] = 16'hFFFF;
      mem[1] = 16'hFFFF;
      mem[8'hFF] = 16'h5000;
      cyc(2'b00, 32'd0);
      cyc(2'b00, 32'd0);
      check("t5_addr_top", {32'd0, imemAddr}, 64'hFFFF_FFFF);
      mem[0] = 16'h0000;              // boot words consumed; index 0 reused
      cyc(2'b00, 32'd0);
      check("t5_fpc",   {32'd0, fetchedPc}, 64'hFFFF_FFFF);
      check("t5_instr", {48'd0, instrOut},  64'h5000);
      check("t5_wrap",  {32'd0, imemAddr},  64'h0);

      // ---- 6: reset while the immediate is pending -------------------------
      load_two_word_prog();
      do_reset();
      cyc(2'b00, 32'd0);
      cyc(2'b00, 32'd0);
      cyc(2'b00, 32'd0);
      rst = 1'b1;
      cyc(2'b00, 32'd0);
      rst = 1'b0;
      check("t6_valid", {63'd0, validOut}, 64'h0);
      check("t6_imm",   {48'd0, immOut},   64'h0);
      check("t6_instr", {48'd0, instrOut}, 64'h0);
      check("t6_addr",  {32'd0, imemAddr}, 64'h0);

      // ---- randomized run --------------------------------------------------
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 149) == 0);
         r = int'($urandom_range(0, 9));
         if ($urandom_range(0, 24) == 0)
            mem[$urandom_range(0, 255)] = 16'($urandom);
         cyc((r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11,
             $urandom);
      end
      rst = 1'b0;
      cyc(2'b00, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
